rbe_scale_ctrl: RTL
===================

# rbe_scale_ctrl

Sequencer for the RBE bit-serial scale stage. For each output tile, it steps the scale stage's shift selector over every (weight bit, activation bit) pair of a quantized multiply, one accepted stream beat per pair. It also emits tile-clear, last-beat and done markers for the downstream accumulator. It sits between the RBE top-level controller (configuration plus start) and the scale datapath, whose stream handshake it observes and gates.

## Interface
Parameters:
- N_SHIFTS, 16: number of shift positions in the scale stage; shift_sel width is SEL_W = $clog2(N_SHIFTS).
- BW_MAX, 8: maximum bit width of weights and activations; counter width is BW_W = $clog2(BW_MAX+1).
- TILE_W, 16: width of the tile counter.

Ports:
- clk_i, in, 1: clock. One clock domain.
- rst_i, in, 1: reset, synchronous, active-high.
- start_i, in, 1: start pulse. Sampled only in IDLE.
- qa_i, in, BW_W: activation bit count, valid range 1..BW_MAX.
- qw_i, in, BW_W: weight bit count, valid range 1..BW_MAX.
- n_tiles_i, in, TILE_W: number of tiles, valid range ≥1.
- beat_valid_i, in, 1: valid of the scale-stage input stream.
- beat_ready_i, in, 1: ready of the scale-stage output stream, as seen by the upstream producer.
- enable_o, out, 1: stream gate; the scale stage passes beats only while this is high.
- shift_sel_o, out, SEL_W: drives the shift selector of the scale stage's control input.
- clear_o, out, 1: high on the first beat of each tile.
- last_o, out, 1: high on the last beat of each tile.
- done_o, out, 1: one-cycle pulse when the job completes.
- err_o, out, 1: one-cycle pulse when a configuration is rejected.
- busy_o, out, 1: high in RUN and DONE.

## Operation
- FSM states are IDLE, RUN and DONE.
- **IDLE:**
  - On start_i, latch qa, qw and n_tiles, then validate them.
  - The configuration is invalid if qa==0, qw==0, qa>BW_MAX, qw>BW_MAX, n_tiles==0, or qa+qw-2 ≥ N_SHIFTS.
  - Invalid: pulse err_o the next cycle and stay in IDLE.
  - Valid: zero all counters and go to RUN.
- **RUN:**
  - An accepted beat is a cycle with beat_valid_i && beat_ready_i && enable_o.
  - Each accepted beat advances a_idx (the inner loop).
  - At a_idx==qa-1, a_idx wraps to 0 and w_idx advances.
  - At w_idx==qw-1 with the wrap, w_idx wraps and the tile counter advances.
  - After the last beat of tile n_tiles-1, go to DONE.
- **DONE:** pulse done_o, then return to IDLE.
- **Outputs:**
  - shift_sel_o = a_idx + w_idx, zero-extended to SEL_W. It never exceeds qa+qw-2, which validation guarantees is below N_SHIFTS.
  - clear_o = RUN && a_idx==0 && w_idx==0.
  - last_o = RUN && a_idx==qa-1 && w_idx==qw-1.
  - enable_o = (state==RUN).
- **Boundary conditions:**
  - start_i is ignored in RUN and DONE.
  - When qa==qw==1, each beat is a full tile, and clear_o and last_o are high together.
  - A stall (valid or ready low) holds all counters and outputs.
  - rst_i mid-job returns the FSM to IDLE and zeroes all counters and outputs; no done_o or err_o pulse is generated.

## Timing
- All outputs are registered, or decoded from registered state only. There is no combinational path from input to output.
- Reset values: enable_o=0, shift_sel_o=0, clear_o=0, last_o=0, done_o=0, err_o=0, busy_o=0.
- Start to RUN: the cycle after start_i, enable_o is high and shift_sel_o is 0.
- shift_sel_o applies to the beat presented in the same cycle. It updates in the cycle after an accepted beat.
- Completion: the last accepted beat is in cycle t, done_o is high in cycle t+1, and the FSM is in IDLE in cycle t+2. A new start_i is accepted from t+2.
- Throughput: one pair per cycle with no bubbles between tiles.
- Job length: qa·qw·n_tiles accepted beats.

## Configuration
- Macro: RBE_SCALE_CTRL_SIGNED_EN.
- With the macro defined:
  - Add ports signed_a_i and signed_w_i (in, 1), latched at start.
  - Add port neg_o (out, 1): neg_o = (signed_w && w_idx==qw-1) XOR (signed_a && a_idx==qa-1), so the accumulator subtracts MSB-weighted partial products.
  - neg_o is 0 outside RUN and on reset.
- Without the macro: these ports are absent and all products are unsigned.

## Structure
- Shared package rbe_package:
  - Add ctrl_scale_ctrl_t with fields qa, qw, n_tiles and, under the macro, signed_a and signed_w.
  - Add flags_scale_ctrl_t with fields busy, done, err, clear and last.
  - Add an enum for the FSM states.
  - shift_sel_o feeds the existing ctrl_scale_t.shift_sel field.
- Sub-module rbe_scale_ctrl_cnt: a counter with wrap and a configurable terminal value, instantiated for a_idx, w_idx and the tile counter.

## Test plan
- qa=2, qw=2, n_tiles=1, stream always valid and ready → shift_sel sequence 0,1,1,2; clear on beat 0; last on beat 3; done_o one cycle after beat 3.
- qa=3, qw=1, n_tiles=2, with ready low every other cycle → 6 accepted beats, sequence 0,1,2,0,1,2; outputs hold during stalls; clear on beats 0 and 3.
- Invalid configurations: qa=0; and qa=8, qw=10 with N_SHIFTS=16 → err_o pulses once, busy_o stays 0, enable_o stays 0.
- start_i re-asserted during RUN (qa=qw=2, n_tiles=3) → ignored; exactly 12 beats, then done_o.
- rst_i asserted after beat 2 of a qa=qw=4 job → the next cycle all outputs are 0 and the FSM is in IDLE; a fresh start then runs the full 16 beats.
- With RBE_SCALE_CTRL_SIGNED_EN, qa=2, qw=2, signed_w=1, signed_a=1 → neg_o sequence 0,1,1,0.

Source files
------------

// File: rtl/rbe_package.sv
// Shared RBE types: scale-stage control/flag structs and the scale sequencer state enum.
// Fields marked with RBE_SCALE_CTRL_SIGNED_EN exist only when signed products are enabled.
package rbe_package;

    localparam int RBE_N_SHIFTS = 16;
    localparam int RBE_SEL_W    = $clog2(RBE_N_SHIFTS);
    localparam int RBE_BW_MAX   = 8;
    localparam int RBE_BW_W     = $clog2(RBE_BW_MAX + 1);
    localparam int RBE_TILE_W   = 16;

    typedef struct packed {
        logic [RBE_SEL_W-1:0] shift_sel;
    } ctrl_scale_t;

    typedef struct packed {
        logic [RBE_BW_W-1:0]   qa;
        logic [RBE_BW_W-1:0]   qw;
        logic [RBE_TILE_W-1:0] n_tiles;
`ifdef RBE_SCALE_CTRL_SIGNED_EN
        logic                  signed_a;
        logic                  signed_w;
`endif
    } ctrl_scale_ctrl_t;

    typedef struct packed {
        logic busy;
        logic done;
        logic err;
        logic clear;
        logic last;
    } flags_scale_ctrl_t;

    typedef enum logic [1:0] {
        SCALE_CTRL_IDLE,
        SCALE_CTRL_RUN,
        SCALE_CTRL_DONE
    } scale_ctrl_state_e;

    // The largest shift a job can request is qa+qw-2, so it must index inside the shifter.
    function automatic logic scale_cfg_invalid(input int qa, input int qw, input int n_tiles,
                                               input int bw_max, input int n_shifts);
        return (qa == 0) || (qw == 0) || (qa > bw_max) || (qw > bw_max) ||
               (n_tiles == 0) || (qa + qw - 2 >= n_shifts);
    endfunction

endpackage

// File: rtl/rbe_scale_ctrl_cnt.sv
// Index counter for the scale sequencer: steps on inc_i and wraps to zero after term_i.
module rbe_scale_ctrl_cnt #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clear_i,
    input  logic         inc_i,
    input  logic [W-1:0] term_i,
    output logic [W-1:0] count_o
);

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            count_o <= '0;
        end else if (inc_i) begin
            count_o <= (count_o == term_i) ? '0 : count_o + W'(1);
        end
    end

endmodule

// File: rtl/rbe_scale_ctrl.sv
// RBE scale-stage sequencer: walks every (weight bit, activation bit) pair per tile.
// Optional signed products are enabled with the macro RBE_SCALE_CTRL_SIGNED_EN.
module rbe_scale_ctrl
    import rbe_package::*;
#(
    parameter int N_SHIFTS = 16,
    parameter int BW_MAX   = 8,
    parameter int TILE_W   = 16,
    localparam int SEL_W   = $clog2(N_SHIFTS),
    localparam int BW_W    = $clog2(BW_MAX + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [BW_W-1:0]   qa_i,
    input  logic [BW_W-1:0]   qw_i,
    input  logic [TILE_W-1:0] n_tiles_i,
    input  logic              beat_valid_i,
    input  logic              beat_ready_i,
`ifdef RBE_SCALE_CTRL_SIGNED_EN
    input  logic              signed_a_i,
    input  logic              signed_w_i,
    output logic              neg_o,
`endif
    output logic              enable_o,
    output logic [SEL_W-1:0]  shift_sel_o,
    output logic              clear_o,
    output logic              last_o,
    output logic              done_o,
    output logic              err_o,
    output logic              busy_o
);

    scale_ctrl_state_e state;
    flags_scale_ctrl_t flags;

    logic [BW_W-1:0]   qa_q, qw_q, qa_m1, qw_m1;
    logic [TILE_W-1:0] n_tiles_q, tiles_m1;
    logic [BW_W-1:0]   a_idx, w_idx;
    logic [TILE_W-1:0] tile_idx;
    logic [BW_W:0]     idx_sum;
    logic              err_q;
    logic              run, accept, a_last, w_last, tile_last;
    logic              w_inc, tile_inc, job_end, cfg_bad, start_ok;

    assign run       = (state == SCALE_CTRL_RUN);
    assign accept    = run && beat_valid_i && beat_ready_i;
    assign qa_m1     = qa_q - BW_W'(1);
    assign qw_m1     = qw_q - BW_W'(1);
    assign tiles_m1  = n_tiles_q - TILE_W'(1);
    assign a_last    = (a_idx == qa_m1);
    assign w_last    = (w_idx == qw_m1);
    assign tile_last = (tile_idx == tiles_m1);
    assign w_inc     = accept && a_last;
    assign tile_inc  = w_inc && w_last;
    assign job_end   = tile_inc && tile_last;

    assign cfg_bad  = scale_cfg_invalid(int'(qa_i), int'(qw_i), int'(n_tiles_i), BW_MAX, N_SHIFTS);
    assign start_ok = (state == SCALE_CTRL_IDLE) && start_i && !cfg_bad;

    // Activation index is the inner loop; weight and tile indices carry from it.
    rbe_scale_ctrl_cnt #(.W(BW_W)) u_a_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (start_ok),
        .inc_i   (accept),
        .term_i  (qa_m1),
        .count_o (a_idx)
    );

    rbe_scale_ctrl_cnt #(.W(BW_W)) u_w_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (start_ok),
        .inc_i   (w_inc),
        .term_i  (qw_m1),
        .count_o (w_idx)
    );

    rbe_scale_ctrl_cnt #(.W(TILE_W)) u_tile_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (start_ok),
        .inc_i   (tile_inc),
        .term_i  (tiles_m1),
        .count_o (tile_idx)
    );

`ifdef RBE_SCALE_CTRL_SIGNED_EN
    logic signed_a_q, signed_w_q;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= SCALE_CTRL_IDLE;
            qa_q      <= '0;
            qw_q      <= '0;
            n_tiles_q <= '0;
            err_q     <= 1'b0;
`ifdef RBE_SCALE_CTRL_SIGNED_EN
            signed_a_q <= 1'b0;
            signed_w_q <= 1'b0;
`endif
        end else begin
            err_q <= 1'b0;
            case (state)
                SCALE_CTRL_IDLE: begin
                    if (start_i) begin
                        qa_q      <= qa_i;
                        qw_q      <= qw_i;
                        n_tiles_q <= n_tiles_i;
`ifdef RBE_SCALE_CTRL_SIGNED_EN
                        signed_a_q <= signed_a_i;
                        signed_w_q <= signed_w_i;
`endif
                        if (cfg_bad) begin
                            err_q <= 1'b1;
                        end else begin
                            state <= SCALE_CTRL_RUN;
                        end
                    end
                end
                SCALE_CTRL_RUN: begin
                    if (job_end) begin
                        state <= SCALE_CTRL_DONE;
                    end
                end
                SCALE_CTRL_DONE: state <= SCALE_CTRL_IDLE;
                default:         state <= SCALE_CTRL_IDLE;
            endcase
        end
    end

    // Outputs decode only registered state, so nothing from the inputs reaches them combinationally.
    assign idx_sum = {1'b0, a_idx} + {1'b0, w_idx};

    always_comb begin
        flags       = '0;
        flags.busy  = (state != SCALE_CTRL_IDLE);
        flags.done  = (state == SCALE_CTRL_DONE);
        flags.err   = err_q;
        flags.clear = run && (a_idx == '0) && (w_idx == '0);
        flags.last  = run && a_last && w_last;
    end

    assign enable_o    = run;
    assign shift_sel_o = run ? SEL_W'(idx_sum) : '0;
    assign clear_o     = flags.clear;
    assign last_o      = flags.last;
    assign done_o      = flags.done;
    assign err_o       = flags.err;
    assign busy_o      = flags.busy;

`ifdef RBE_SCALE_CTRL_SIGNED_EN
    assign neg_o = run && ((signed_w_q && w_last) ^ (signed_a_q && a_last));
`endif

endmodule
